// File: rtl/bullet_oam_writer.sv
// Copies a frame's bullet state words into OAM, one valid/ready write per entry.
// Latency: first write one cycle after frame_start; stalls hold address and data while oam_ready is low.
module bullet_oam_writer #(
  parameter int MAX_BULLETS = 8,
  parameter int OAM_BASE    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [31:0] bullet_state [0:MAX_BULLETS-1],
  input  logic        oam_ready,
  output logic        oam_we,
  output logic [5:0]  oam_addr,
  output logic [31:0] oam_wdata,
  output logic        busy,
  output logic        done,
  output logic [3:0]  active_count,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  localparam logic [5:0] BASE = 6'(OAM_BASE);
  localparam logic [3:0] LAST = 4'(MAX_BULLETS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  index;
  logic [3:0]  run_cnt;
  logic [31:0] snap [0:15];
  logic [31:0] src  [0:15];
  logic        start;
  logic        accept;

  // Pad the input bank to 16 entries so the 4-bit index always selects a real register.
  for (genvar g = 0; g < 16; g++) begin : g_src
    if (g < MAX_BULLETS) begin : g_used
      assign src[g] = bullet_state[g];
    end else begin : g_pad
      assign src[g] = '0;
    end
  end

  assign start  = (state == S_IDLE) && frame_start;
  assign accept = (state == S_WRITE) && oam_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = S_WRITE;
      S_WRITE: if (oam_ready && index == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oam_we    = 1'b0;
    oam_addr  = '0;
    oam_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_WRITE: begin
        oam_we    = 1'b1;
        oam_addr  = BASE + {2'b00, index};
        oam_wdata = snap[index];
        busy      = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index        <= '0;
      run_cnt      <= '0;
      active_count <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < 16; i++) snap[i] <= '0;
    end else begin
      if (frame_start && state != S_IDLE) overrun <= 1'b1;
      if (start) begin
        for (int i = 0; i < 16; i++) snap[i] <= src[i];
        index   <= '0;
        run_cnt <= '0;
      end else if (accept) begin
        index   <= (index == LAST) ? 4'd0 : index + 4'd1;
        run_cnt <= run_cnt + {3'b000, snap[index][28]};
      end
      if (state == S_DONE) active_count <= run_cnt;
    end
  end

endmodule

// File: tb/tb_bullet_oam_writer.sv
// Directed bench for bullet_oam_writer: a queue-based frame model checked every cycle,
// plus literal expectations for timing, address sequences and flag behaviour.
module tb_bullet_oam_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [31:0] bs [0:7];
  logic        oam_ready;

  logic        we, busy, done, ovr;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  act;
  logic        we60, busy60, done60, ovr60;
  logic [5:0]  addr60;
  logic [31:0] wdata60;
  logic [3:0]  act60;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bullet_oam_writer dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .bullet_state(bs),
    .oam_ready(oam_ready), .oam_we(we), .oam_addr(addr), .oam_wdata(wdata),
    .busy(busy), .done(done), .active_count(act), .overrun(ovr)
  );

  bullet_oam_writer #(.MAX_BULLETS(8), .OAM_BASE(60)) dut60 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .bullet_state(bs),
    .oam_ready(oam_ready), .oam_we(we60), .oam_addr(addr60), .oam_wdata(wdata60),
    .busy(busy60), .done(done60), .active_count(act60), .overrun(ovr60)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted frame becomes a queue of pending (slot, word) writes.
  typedef struct {
    int          idx;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  logic        m_done = 1'b0;
  logic        m_ovr  = 1'b0;
  logic [3:0]  m_act  = '0;
  logic [3:0]  m_pend = '0;
  logic        m_busy, m_we, nd;
  logic [5:0]  e_addr, e_addr60;
  logic [31:0] e_dat;
  int          acc_q[$];
  int          acc60_q[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
      m_act  = '0;
      m_pend = '0;
    end
    m_we     = (mq.size() > 0);
    m_busy   = m_we || m_done;
    e_addr   = m_we ? 6'(8 + mq[0].idx) : 6'd0;
    e_addr60 = m_we ? 6'(60 + mq[0].idx) : 6'd0;
    e_dat    = m_we ? mq[0].dat : 32'd0;
    chk("oam_we", we, m_we);
    chk("oam_addr", addr, e_addr);
    chk("oam_wdata", wdata, e_dat);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("active_count", act, m_act);
    chk("overrun", ovr, m_ovr);
    chk("oam_we60", we60, m_we);
    chk("oam_addr60", addr60, e_addr60);
    chk("oam_wdata60", wdata60, e_dat);
    chk("done60", done60, m_done);
    chk("active_count60", act60, m_act);
    if (we && oam_ready) acc_q.push_back(int'(addr));
    if (we60 && oam_ready) acc60_q.push_back(int'(addr60));
    if (reset_n) begin
      nd = 1'b0;
      if (m_done) m_act = m_pend;
      if (frame_start && m_busy) m_ovr = 1'b1;
      if (m_we && oam_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) nd = 1'b1;
      end else if (frame_start && !m_busy) begin
        m_pend = '0;
        for (int i = 0; i < 8; i++) begin
          mq.push_back('{idx: i, dat: bs[i]});
          if (bs[i][28]) m_pend = m_pend + 4'd1;
        end
      end
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready=1; 1: ready 1,0,0 repeating; 2: ready=1, inputs scrambled each cycle;
  // 3: ready=1 with extra frame_start pulses in WRITE cycle 3 and in DONE.
  task automatic run_frame(input int mode, output int done_cyc);
    acc_q.delete();
    acc60_q.delete();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      oam_ready   = (mode == 1) ? ((cyc % 3) == 1) : 1'b1;
      frame_start = (mode == 3) && (cyc == 3 || cyc == 9);
      if (mode == 2) for (int i = 0; i < 8; i++) bs[i] = $urandom;
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = cyc;
      tick();
      if (done_cyc != 0) break;
    end
    frame_start = 1'b0;
    oam_ready   = 1'b1;
    chk("done_seen", (done_cyc != 0), 1'b1);
  endtask

  task automatic chk_addr_seq();
    int exp60 [8];
    exp60 = '{60, 61, 62, 63, 0, 1, 2, 3};
    chk("accepted_count", acc_q.size(), 8);
    chk("accepted_count60", acc60_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_q.size()) chk("addr_seq", acc_q[i], 8 + i);
      if (i < acc60_q.size()) chk("addr_seq60", acc60_q[i], exp60[i]);
    end
  endtask

  int dc;

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b1;
    oam_ready   = 1'b1;
    for (int i = 0; i < 8; i++) bs[i] = 32'h1000_0000 + i;
    tick(); tick(); tick();
    frame_start = 1'b0;
    reset_n     = 1'b1;
    tick();
    chk("idle_we_lit", we, 1'b0);
    chk("idle_busy_lit", busy, 1'b0);

    for (int i = 0; i < 8; i++) bs[i] = 32'h0;
    bs[0] = 32'h1234_5678;
    bs[3] = 32'hF0AB_CDEF;
    bs[5] = 32'h5000_00C3;
    run_frame(0, dc);
    chk("done_cycle_ready1", dc, 9);
    chk("active_count_lit", act, 3);
    chk_addr_seq();

    for (int i = 0; i < 8; i++) bs[i] = (i % 2 == 1) ? 32'h1000_0000 | (i << 8) : 32'h0EEE_0000 + i;
    run_frame(1, dc);
    chk("done_cycle_stall", dc, 23);
    chk("active_count_stall", act, 4);
    chk_addr_seq();

    for (int i = 0; i < 8; i++) bs[i] = 32'h1111_0000 * i;
    run_frame(2, dc);
    chk("done_cycle_scramble", dc, 9);
    chk_addr_seq();

    for (int i = 0; i < 8; i++) bs[i] = 32'hFFFF_FFFF;
    chk("overrun_before", ovr, 1'b0);
    run_frame(3, dc);
    chk("done_cycle_overrun", dc, 9);
    chk("overrun_lit", ovr, 1'b1);
    chk("active_count_all", act, 8);
    chk_addr_seq();
    tick();
    run_frame(0, dc);
    chk("overrun_sticky", ovr, 1'b1);
    chk_addr_seq();

    // Reset while slot 4 is stalled.
    for (int i = 0; i < 8; i++) bs[i] = 32'hA000_0000 + i;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    oam_ready = 1'b0;
    #2;
    chk("stall_addr_lit", addr, 12);
    chk("stall_we_lit", we, 1'b1);
    reset_n = 1'b0;
    frame_start = 1'b1;
    #1;
    chk("rst_we_lit", we, 1'b0);
    chk("rst_addr_lit", addr, 0);
    chk("rst_wdata_lit", wdata, 0);
    chk("rst_busy_lit", busy, 1'b0);
    chk("rst_overrun_lit", ovr, 1'b0);
    tick(); tick();
    frame_start = 1'b0;
    oam_ready   = 1'b1;
    reset_n     = 1'b1;
    tick(); tick();
    chk("post_rst_idle", busy, 1'b0);
    run_frame(0, dc);
    chk("done_cycle_post_rst", dc, 9);
    chk_addr_seq();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bullet_oam_writer.md
BULLET_OAM_WRITER -- requirements
Module: bullet_oam_writer

Interface
REQ-001 SHALL have parameter MAX_BULLETS, default 8, number of bullet entries consumed (1..15).
REQ-002 SHALL have parameter OAM_BASE, default 8, first OAM address used for bullet entries.
REQ-003 SHALL have port clk, input, 1, single system clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port frame_start, input, 1, one-cycle pulse at start of vertical blank.
REQ-006 SHALL have port bullet_state, input, 32 x [0:MAX_BULLETS-1], per-bullet state words.
REQ-007 SHALL have port oam_ready, input, 1, OAM accepts a write this cycle.
REQ-008 SHALL have port oam_we, output, 1, write request valid.
REQ-009 SHALL have port oam_addr, output, 6, OAM target address.
REQ-010 SHALL have port oam_wdata, output, 32, OAM write data.
REQ-011 SHALL have port busy, output, 1, high while a frame update is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when all entries have been written.
REQ-013 SHALL have port active_count, output, 4, number of entries with active bit set in last completed frame.
REQ-014 SHALL have port overrun, output, 1, sticky flag: frame_start arrived while not IDLE.

Function
REQ-015 SHALL treat state word fields as: [31] pad, [30:29] type, [28] active, [27:18] x, [17:8] y, [7:6] dir, [5:3] rom_row, [2:0] rom_col.
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-017 SHALL, in IDLE on frame_start=1, copy all MAX_BULLETS words into a snapshot register bank, set index=0, go to WRITE next cycle.
REQ-018 SHALL ignore bullet_state changes after the snapshot edge until the next accepted frame_start.
REQ-019 SHALL, in WRITE, drive oam_we=1, oam_addr=OAM_BASE+index (6-bit, truncating wrap), oam_wdata=snapshot[index].
REQ-020 SHALL hold oam_addr and oam_wdata stable while oam_we=1 and oam_ready=0.
REQ-021 SHALL count a write as accepted only on a cycle with oam_we=1 and oam_ready=1; index increments by 1 per accepted write.
REQ-022 SHALL accumulate a running count of snapshot words with bit[28]=1 as each is accepted.
REQ-023 SHALL, on acceptance of index MAX_BULLETS-1, go to DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-024 SHALL assert done=1 only in DONE and load active_count with the running count in that same cycle's edge.
REQ-025 SHALL write every entry, active or not, so inactive slots overwrite stale OAM contents.
REQ-026 SHALL drive busy=1 in WRITE and DONE, 0 in IDLE; oam_we=0 outside WRITE.
REQ-027 SHALL, on frame_start=1 in WRITE or DONE, ignore the pulse (no restart, no snapshot) and set overrun=1.
REQ-028 SHALL keep overrun set until reset_n is asserted.
REQ-029 SHALL, with oam_ready held 1 continuously, complete a frame in MAX_BULLETS WRITE cycles plus 1 DONE cycle (first oam_we one cycle after frame_start).

Reset
REQ-030 SHALL, on reset_n=0, immediately force IDLE, oam_we=0, oam_addr=0, oam_wdata=0, busy=0, done=0, active_count=0, overrun=0, index=0, running count=0, snapshot bank=0.
REQ-031 SHALL abandon any in-progress frame when reset is asserted mid-WRITE; no further writes until a new frame_start after release.
REQ-032 SHALL not respond to a frame_start coinciding with reset_n=0.

Verification
REQ-033 Frame, ready=1, entries 0/3/5 active (bit28=1), others 0 -> writes addr 8..15 in 8 consecutive cycles, data equals inputs at snapshot edge, done pulse at cycle 9, active_count=3.
REQ-034 oam_ready toggles 1,0,0,1,... -> each addr/data held during stalls, 8 accepted writes, no duplicate or skipped address.
REQ-035 bullet_state changed every cycle during WRITE -> all written data equals snapshot captured at frame_start edge.
REQ-036 frame_start pulsed at 3rd WRITE cycle and in DONE -> frame continues unchanged, overrun=1 and stays 1 across later clean frames.
REQ-037 reset_n dropped at index 4 with ready=0 -> oam_we=0 same cycle, all outputs zero; next frame_start restarts at addr 8.
REQ-038 OAM_BASE=60, MAX_BULLETS=8 -> addresses 60,61,62,63,0,1,2,3.
